// File: rtl/button_press_if.sv
// button_press_if
//   Request/status bundle between a press requester and button_press_gen.
//   Signals:
//     req      requester -> generator  one-cycle press request
//     clr_ovf  requester -> generator  clears the sticky overflow flag
//     btn_n    generator -> requester  emulated active-low button
//     busy     generator -> requester  a press or its recovery gap is in progress
//     done     generator -> requester  one-cycle pulse when btn_n returns high
//     pending  generator -> requester  queued requests not yet started
//     overflow generator -> requester  sticky, a request was dropped
//   Modports: master = requester side, slave = generator side.
interface button_press_if #(
  parameter int QUEUE_W = 3
);
  logic               req;
  logic               clr_ovf;
  logic               btn_n;
  logic               busy;
  logic               done;
  logic [QUEUE_W-1:0] pending;
  logic               overflow;

  modport master (
    output req, clr_ovf,
    input  btn_n, busy, done, pending, overflow
  );

  modport slave (
    input  req, clr_ovf,
    output btn_n, busy, done, pending, overflow
  );
endinterface

// File: rtl/button_press_gen.sv
// button_press_gen
//   Turns one-cycle press requests into clean active-low button presses for a
//   downstream debouncer: each press is HOLD_CYCLES low followed by GAP_CYCLES
//   high. Requests arriving while a press is in flight are queued in a
//   saturating counter; a request that finds the queue full is dropped and
//   raises a sticky overflow flag.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous reset, active low (0 = reset)
//     bus    button_press_if.slave: req, clr_ovf in; btn_n, busy, done,
//            pending, overflow out (all registered)
module button_press_gen #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 65536,
  parameter int CNT_W       = 17,
  parameter int QUEUE_W     = 3
) (
  input logic           clk,
  input logic           reset,
  button_press_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMER_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   TIMER_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [QUEUE_W-1:0] PEND_ZERO  = {QUEUE_W{1'b0}};
  localparam logic [QUEUE_W-1:0] PEND_ONE   = {{(QUEUE_W-1){1'b0}}, 1'b1};
  localparam logic [QUEUE_W-1:0] PEND_MAX   = {QUEUE_W{1'b1}};

  state_t             state_r;
  logic [CNT_W-1:0]   timer_r;
  logic               btn_n_r;
  logic               busy_r;
  logic               done_r;
  logic [QUEUE_W-1:0] pending_r;
  logic               overflow_r;

  logic               press_last_s;
  logic               gap_last_s;
  logic               pend_nz_s;
  logic               enq_s;
  logic               deq_s;
  logic               drop_s;
  logic [QUEUE_W-1:0] pending_nxt_s;

  assign bus.btn_n    = btn_n_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.pending  = pending_r;
  assign bus.overflow = overflow_r;

  // Queue bookkeeping: what this edge adds to and removes from the pending count.
  always_comb begin
    press_last_s  = (state_r == ST_PRESS) && (timer_r == HOLD_LAST);
    gap_last_s    = (state_r == ST_GAP) && (timer_r == GAP_LAST);
    pend_nz_s     = (pending_r != PEND_ZERO);
    // A request is queued unless it can start directly from an empty idle.
    enq_s         = bus.req && ((state_r != ST_IDLE) || pend_nz_s);
    // A queued press starts from idle, or at the end of a gap when the queue
    // (including a request arriving on this very edge) is non-empty.
    deq_s         = ((state_r == ST_IDLE) && pend_nz_s) ||
                    (gap_last_s && (pend_nz_s || bus.req));
    // A simultaneous dequeue frees a slot, so the request is never lost then.
    drop_s        = enq_s && !deq_s && (pending_r == PEND_MAX);
    pending_nxt_s = pending_r;
    case ({enq_s, deq_s})
      2'b10:   pending_nxt_s = drop_s ? pending_r : (pending_r + PEND_ONE);
      2'b01:   pending_nxt_s = pending_r - PEND_ONE;
      default: pending_nxt_s = pending_r;
    endcase
  end

  // Press FSM with registered outputs, queue counter and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      timer_r    <= TIMER_ZERO;
      btn_n_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pending_r  <= PEND_ZERO;
      overflow_r <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      // A fresh drop wins over a clear on the same edge.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          timer_r <= TIMER_ZERO;
          if (bus.req || pend_nz_s) begin
            state_r <= ST_PRESS;
            btn_n_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            btn_n_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ST_PRESS: begin
          if (press_last_s) begin
            state_r <= ST_GAP;
            timer_r <= TIMER_ZERO;
            btn_n_r <= 1'b1;
            done_r  <= 1'b1;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        ST_GAP: begin
          if (gap_last_s) begin
            timer_r <= TIMER_ZERO;
            if (deq_s) begin
              // Next queued press follows with no idle cycle in between.
              state_r <= ST_PRESS;
              btn_n_r <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          timer_r <= TIMER_ZERO;
          btn_n_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_gen.sv
// tb_button_press_gen
//   Directed bench for button_press_gen with HOLD_CYCLES=3, GAP_CYCLES=5,
//   QUEUE_W=2. Cycle numbering: cycle N is the interval after clock edge N;
//   an input driven in cycle N is sampled at the edge starting cycle N+1.
//   Outputs are sampled 1 time unit after each rising edge.
module tb_button_press_gen;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  button_press_if #(.QUEUE_W(2)) bus ();

  button_press_gen #(
    .HOLD_CYCLES(3),
    .GAP_CYCLES (5),
    .CNT_W      (17),
    .QUEUE_W    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with req held high, then confirm nothing starts after release.
  task automatic test_reset();
    int lows;
    reset = 1'b0;
    bus.req = 1'b1;
    bus.clr_ovf = 1'b0;
    tick();
    tick();
    checks++; if (bus.btn_n !== 1'b1) begin errors++; $display("FAIL reset_btn_n got=%b exp=1", bus.btn_n); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", bus.pending); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    reset = 1'b1;
    bus.req = 1'b0;
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.btn_n !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL reset_no_press got=%0d low cycles exp=0", lows); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", bus.busy); end
  endtask

  // One request: low cycles 11-13, done at 14, busy clears at 19.
  task automatic test_single();
    logic [8:0] exp_btn;
    logic [8:0] exp_done;
    logic [8:0] exp_busy;
    exp_btn  = 9'b111111000;
    exp_done = 9'b000001000;
    exp_busy = 9'b011111111;
    bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++; if (bus.btn_n !== exp_btn[i]) begin errors++; $display("FAIL single_btn_n cyc=%0d got=%b exp=%b", 11 + i, bus.btn_n, exp_btn[i]); end
      checks++; if (bus.done !== exp_done[i]) begin errors++; $display("FAIL single_done cyc=%0d got=%b exp=%b", 11 + i, bus.done, exp_done[i]); end
      checks++; if (bus.busy !== exp_busy[i]) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", 11 + i, bus.busy, exp_busy[i]); end
      tick();
    end
  endtask

  // Requests at 10 and 12: queued once, second press 19-21, done at 14 and 22.
  task automatic test_queue();
    logic [16:0] exp_btn;
    logic [16:0] exp_done;
    logic [16:0] exp_busy;
    logic [16:0] exp_pend;
    logic [1:0]  pend_e;
    exp_btn  = 17'b11111100011111000;
    exp_done = 17'b00000100000001000;
    exp_busy = 17'b01111111111111111;
    exp_pend = 17'b00000000011111100;
    bus.req = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      pend_e = {1'b0, exp_pend[i]};
      checks++; if (bus.btn_n !== exp_btn[i]) begin errors++; $display("FAIL queue_btn_n cyc=%0d got=%b exp=%b", 11 + i, bus.btn_n, exp_btn[i]); end
      checks++; if (bus.done !== exp_done[i]) begin errors++; $display("FAIL queue_done cyc=%0d got=%b exp=%b", 11 + i, bus.done, exp_done[i]); end
      checks++; if (bus.busy !== exp_busy[i]) begin errors++; $display("FAIL queue_busy cyc=%0d got=%b exp=%b", 11 + i, bus.busy, exp_busy[i]); end
      checks++; if (bus.pending !== pend_e) begin errors++; $display("FAIL queue_pending cyc=%0d got=%0d exp=%0d", 11 + i, bus.pending, pend_e); end
      bus.req = (i == 1);
      tick();
    end
    bus.req = 1'b0;
  endtask

  // A request on the last gap cycle chains straight into the next press.
  task automatic test_back_to_back();
    logic [16:0] exp_btn;
    logic [16:0] exp_done;
    logic [16:0] exp_busy;
    exp_btn  = 17'b11111100011111000;
    exp_done = 17'b00000100000001000;
    exp_busy = 17'b01111111111111111;
    bus.req = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      checks++; if (bus.btn_n !== exp_btn[i]) begin errors++; $display("FAIL b2b_btn_n cyc=%0d got=%b exp=%b", 11 + i, bus.btn_n, exp_btn[i]); end
      checks++; if (bus.done !== exp_done[i]) begin errors++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", 11 + i, bus.done, exp_done[i]); end
      checks++; if (bus.busy !== exp_busy[i]) begin errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", 11 + i, bus.busy, exp_busy[i]); end
      checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL b2b_pending cyc=%0d got=%0d exp=0", 11 + i, bus.pending); end
      bus.req = (i == 7);
      tick();
    end
    bus.req = 1'b0;
  endtask

  // req held on cycles 10-15: saturates at 3, drops set overflow, clr_ovf
  // together with a drop keeps it set, exactly 4 presses come out.
  task automatic test_overflow();
    logic [1:0] exp_pend [5];
    logic       exp_ovf  [5];
    logic       prev_btn;
    logic       idle_seen;
    int         presses;
    exp_pend = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    exp_ovf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    presses   = 0;
    prev_btn  = 1'b1;
    idle_seen = 1'b0;
    bus.req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.pending !== exp_pend[i]) begin errors++; $display("FAIL ovf_pending cyc=%0d got=%0d exp=%0d", 11 + i, bus.pending, exp_pend[i]); end
      checks++; if (bus.overflow !== exp_ovf[i]) begin errors++; $display("FAIL ovf_flag cyc=%0d got=%b exp=%b", 11 + i, bus.overflow, exp_ovf[i]); end
      if (prev_btn && !bus.btn_n) presses++;
      prev_btn = bus.btn_n;
      bus.clr_ovf = (i == 4);
      tick();
    end
    bus.req = 1'b0;
    bus.clr_ovf = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_drop got=%b exp=1", bus.overflow); end
    checks++; if (bus.pending !== 2'd3) begin errors++; $display("FAIL ovf_pending_hold got=%0d exp=3", bus.pending); end
    for (int i = 0; i < 60; i++) begin
      if (!idle_seen) begin
        if (prev_btn && !bus.btn_n) presses++;
        prev_btn = bus.btn_n;
        if (!bus.busy) idle_seen = 1'b1;
        else tick();
      end
    end
    checks++; if (!idle_seen) begin errors++; $display("FAIL ovf_idle_timeout got=busy exp=idle within 60 cycles"); end
    checks++; if (presses !== 4) begin errors++; $display("FAIL ovf_press_count got=%0d exp=4", presses); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL ovf_drained got=%0d exp=0", bus.pending); end
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
  endtask

  // Reset during a press with two queued: everything clears, nothing resumes.
  task automatic test_reset_mid_press();
    int lows;
    bus.req = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (bus.btn_n !== 1'b0) begin errors++; $display("FAIL midrst_pre_btn_n got=%b exp=0", bus.btn_n); end
    checks++; if (bus.pending !== 2'd2) begin errors++; $display("FAIL midrst_pre_pending got=%0d exp=2", bus.pending); end
    bus.req = 1'b0;
    reset = 1'b0;
    tick();
    checks++; if (bus.btn_n !== 1'b1) begin errors++; $display("FAIL midrst_btn_n got=%b exp=1", bus.btn_n); end
    checks++; if (bus.pending !== 2'd0) begin errors++; $display("FAIL midrst_pending got=%0d exp=0", bus.pending); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.btn_n !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin errors++; $display("FAIL midrst_no_press got=%0d low cycles exp=0", lows); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.req = 1'b0;
    bus.clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_queue();
    test_back_to_back();
    test_overflow();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
